// File: rtl/simd_result_queue_pkg.sv
// Types and default parameters shared by the SIMD result queue and its testbench.
`include "simd_result_queue.vh"

package simd_result_queue_pkg;

    typedef enum logic {
        MODE_AUTO  = `SRQ_MODE_AUTO,
        MODE_FLUSH = `SRQ_MODE_FLUSH
    } srq_mode_e;

    localparam int DEF_NUM_LANES  = `SRQ_DEF_NUM_LANES;
    localparam int DEF_LANE_WIDTH = `SRQ_DEF_LANE_WIDTH;
    localparam int DEF_DEPTH      = `SRQ_DEF_DEPTH;

endpackage

// File: rtl/simd_result_fifo.sv
// Synchronous DEPTH-entry FIFO holding committed result vectors; head reads as zero when empty.
module simd_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_poweron,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             push_data,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/simd_result_queue.vh
// Shared definitions for the SIMD result queue: mode encodings and default sizes.
`ifndef SIMD_RESULT_QUEUE_VH
`define SIMD_RESULT_QUEUE_VH

`define SRQ_MODE_AUTO       1'b0
`define SRQ_MODE_FLUSH      1'b1

`define SRQ_DEF_NUM_LANES   32
`define SRQ_DEF_LANE_WIDTH  32
`define SRQ_DEF_DEPTH       4

`ifndef PE_PE_ID_RANGE
`define PE_PE_ID_RANGE 7:0
`endif

`endif

// File: rtl/simd_result_queue.sv
// Assembles per-lane SIMD results into vectors and queues committed vectors for the stack upstream.
`include "simd_result_queue.vh"

module simd_result_queue
    import simd_result_queue_pkg::*;
#(
    parameter int NUM_LANES  = DEF_NUM_LANES,
    parameter int LANE_WIDTH = DEF_LANE_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                              clk,
    input  logic                              reset_poweron,
    input  logic [`PE_PE_ID_RANGE]            peId,
    input  logic [NUM_LANES-1:0]              lane_result_valid,
    input  logic [NUM_LANES*LANE_WIDTH-1:0]   lane_result,
    input  logic [NUM_LANES-1:0]              cfg_lane_mask,
    input  logic                              cfg_mode,
    input  logic                              flush,
    output logic [NUM_LANES*LANE_WIDTH-1:0]   simd__sui__regs,
    output logic [NUM_LANES-1:0]              simd__sui__regs_valid,
    input  logic                              sui__simd__regs_complete,
    output logic [$clog2(DEPTH+1)-1:0]        occupancy,
    output logic                              overflow_err,
    input  logic                              clear_err
);

    localparam int DATA_W  = NUM_LANES*LANE_WIDTH;
    localparam int ENTRY_W = NUM_LANES*(LANE_WIDTH+1);

    logic [DATA_W-1:0]    asm_data;
    logic [DATA_W-1:0]    asm_data_next;
    logic [NUM_LANES-1:0] asm_valid;
    logic [NUM_LANES-1:0] asm_valid_next;
    logic [ENTRY_W-1:0]   head_entry;
    srq_mode_e            mode;
    logic                 commit_cond;
    logic                 commit;
    logic                 pop_req;
    logic                 fifo_full;
    logic                 collision;
    logic                 unused_pe_id;

    assign unused_pe_id = ^peId;
    assign mode         = srq_mode_e'(cfg_mode);
    assign pop_req      = sui__simd__regs_complete && (occupancy != '0);

    // Commit is judged on the registered slot, so a lane strobed this cycle never joins the vector leaving now.
    always_comb begin
        commit_cond = 1'b0;
        if (mode == MODE_AUTO) begin
            commit_cond = (cfg_lane_mask != '0) &&
                          ((asm_valid & cfg_lane_mask) == cfg_lane_mask);
        end else begin
            commit_cond = flush && (asm_valid != '0);
        end
    end

    assign commit    = commit_cond && (!fifo_full || pop_req);
    assign collision = !commit && ((lane_result_valid & asm_valid) != '0);

    always_comb begin
        asm_data_next  = commit ? '0 : asm_data;
        asm_valid_next = (commit ? '0 : asm_valid) | lane_result_valid;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_result_valid[i]) begin
                asm_data_next[i*LANE_WIDTH +: LANE_WIDTH] = lane_result[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    // A new collision takes priority over a clear arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            asm_data     <= '0;
            asm_valid    <= '0;
            overflow_err <= 1'b0;
        end else begin
            asm_data  <= asm_data_next;
            asm_valid <= asm_valid_next;
            if (collision) begin
                overflow_err <= 1'b1;
            end else if (clear_err) begin
                overflow_err <= 1'b0;
            end
        end
    end

    simd_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .reset_poweron (reset_poweron),
        .push          (commit),
        .pop           (pop_req),
        .push_data     ({asm_valid, asm_data}),
        .head_data     (head_entry),
        .count         (occupancy),
        .full          (fifo_full)
    );

    assign simd__sui__regs       = head_entry[DATA_W-1:0];
    assign simd__sui__regs_valid = head_entry[ENTRY_W-1 -: NUM_LANES];

endmodule

// File: tb/tb_simd_result_queue.sv
// Directed, table-driven bench for simd_result_queue with hand-written queue-full and reset sequences.
`include "simd_result_queue.vh"

module tb_simd_result_queue;

    localparam int NL = 32;
    localparam int LW = 32;
    localparam int DP = 4;
    localparam int OW = $clog2(DP+1);

    logic                 clk;
    logic                 reset_poweron;
    logic [`PE_PE_ID_RANGE] pe_id;
    logic [NL-1:0]        lane_result_valid;
    logic [NL*LW-1:0]     lane_result;
    logic [NL-1:0]        cfg_lane_mask;
    logic                 cfg_mode;
    logic                 flush;
    logic [NL*LW-1:0]     regs;
    logic [NL-1:0]        regs_valid;
    logic                 regs_complete;
    logic [OW-1:0]        occupancy;
    logic                 overflow_err;
    logic                 clear_err;

    int total = 0;
    int bad   = 0;

    simd_result_queue #(
        .NUM_LANES  (NL),
        .LANE_WIDTH (LW),
        .DEPTH      (DP)
    ) dut (
        .clk                      (clk),
        .reset_poweron            (reset_poweron),
        .peId                     (pe_id),
        .lane_result_valid        (lane_result_valid),
        .lane_result              (lane_result),
        .cfg_lane_mask            (cfg_lane_mask),
        .cfg_mode                 (cfg_mode),
        .flush                    (flush),
        .simd__sui__regs          (regs),
        .simd__sui__regs_valid    (regs_valid),
        .sui__simd__regs_complete (regs_complete),
        .occupancy                (occupancy),
        .overflow_err             (overflow_err),
        .clear_err                (clear_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [31:0] lmask;
        logic [31:0] strb;
        logic [31:0] base;
        logic        flush;
        logic        cmpl;
        logic        clr;
        logic [31:0] exp_valid;
        int          exp_occ;
        logic        exp_err;
        int          chk_lane;
        logic [31:0] exp_data;
    } vec_t;

    function automatic vec_t mk(logic m, logic [31:0] lm, logic [31:0] st, logic [31:0] b,
                                logic fl, logic cp, logic cl, logic [31:0] ev, int eo,
                                logic ee, int ln, logic [31:0] ed);
        vec_t v;
        v.mode = m; v.lmask = lm; v.strb = st; v.base = b;
        v.flush = fl; v.cmpl = cp; v.clr = cl;
        v.exp_valid = ev; v.exp_occ = eo; v.exp_err = ee;
        v.chk_lane = ln; v.exp_data = ed;
        return v;
    endfunction

    // Strobed lane i carries base + 0x11*i, so expected data is easy to derive by hand.
    task automatic applyStimulus(input logic m, input logic [31:0] lm, input logic [31:0] st,
                                 input logic [31:0] b, input logic fl, input logic cp,
                                 input logic cl);
        cfg_mode          = m;
        cfg_lane_mask     = lm;
        lane_result_valid = st;
        flush             = fl;
        regs_complete     = cp;
        clear_err         = cl;
        lane_result       = '0;
        for (int i = 0; i < NL; i++) begin
            if (st[i]) lane_result[i*LW +: LW] = b + 32'h11 * i;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_of(int ln);
        return regs[ln*LW +: LW];
    endfunction

    vec_t vecs[27];

    localparam logic A = 1'b0;
    localparam logic F = 1'b1;

    initial begin
        pe_id = '1;
        reset_poweron = 1'b1;
        applyStimulus(A, 0, 0, 0, 0, 0, 0);
        applyStimulus(A, 0, 0, 0, 0, 0, 0);
        reset_poweron = 1'b0;

        checkOutput("reset_valid", regs_valid, 0);
        checkOutput("reset_occ", 32'(occupancy), 0);
        checkOutput("reset_err", 32'(overflow_err), 0);
        checkOutput("reset_data", lane_of(0), 0);

        vecs[0]  = mk(A, 'hF, 'hF,  'h11, 0, 0, 0, 0,    0, 0, 0, 0);
        vecs[1]  = mk(A, 'hF, 0,    0,    0, 0, 0, 'hF,  1, 0, 3, 'h44);
        vecs[2]  = mk(A, 'hF, 0,    0,    0, 1, 0, 0,    0, 0, 3, 0);
        vecs[3]  = mk(F, 'hF, 'hA0, 'h01, 0, 0, 0, 0,    0, 0, 5, 0);
        vecs[4]  = mk(F, 'hF, 0,    0,    1, 0, 0, 'hA0, 1, 0, 5, 'h56);
        vecs[5]  = mk(F, 'hF, 0,    0,    1, 0, 0, 'hA0, 1, 0, 7, 'h78);
        vecs[6]  = mk(A, 'hF, 'h1,  'h5,  1, 0, 0, 'hA0, 1, 0, 0, 0);
        vecs[7]  = mk(A, 'hF, 0,    0,    1, 1, 0, 0,    0, 0, 0, 0);
        vecs[8]  = mk(A, 'hF, 'h4,  'h88, 0, 0, 0, 0,    0, 0, 0, 0);
        vecs[9]  = mk(A, 'hF, 'h4,  'h99, 0, 0, 0, 0,    0, 1, 0, 0);
        vecs[10] = mk(A, 'hF, 'hA,  'h10, 0, 0, 0, 0,    0, 1, 0, 0);
        vecs[11] = mk(A, 'hF, 0,    0,    0, 0, 0, 'hF,  1, 1, 2, 'hBB);
        vecs[12] = mk(A, 'hF, 0,    0,    0, 1, 1, 0,    0, 0, 2, 0);
        vecs[13] = mk(F, 'hF, 'h1,  'h7,  0, 0, 0, 0,    0, 0, 0, 0);
        vecs[14] = mk(F, 'hF, 'h1,  'h8,  0, 0, 1, 0,    0, 1, 0, 0);
        vecs[15] = mk(F, 'hF, 0,    0,    0, 0, 1, 0,    0, 0, 0, 0);
        vecs[16] = mk(F, 'hF, 0,    0,    1, 0, 0, 'h1,  1, 0, 0, 'h8);
        vecs[17] = mk(F, 'hF, 0,    0,    0, 1, 0, 0,    0, 0, 0, 0);
        vecs[18] = mk(A, 'h3, 'h3,  'h1,  0, 0, 0, 0,    0, 0, 0, 0);
        vecs[19] = mk(A, 'h3, 'h2,  'h2,  0, 0, 0, 'h3,  1, 0, 1, 'h12);
        vecs[20] = mk(A, 'h3, 'h1,  'h30, 0, 0, 0, 'h3,  1, 0, 0, 'h1);
        vecs[21] = mk(A, 'h3, 0,    0,    0, 1, 0, 'h3,  1, 0, 1, 'h13);
        vecs[22] = mk(A, 'h3, 0,    0,    0, 1, 0, 0,    0, 0, 0, 0);
        vecs[23] = mk(A, 'h0, 'h1,  'h1,  0, 0, 0, 0,    0, 0, 0, 0);
        vecs[24] = mk(A, 'h0, 0,    0,    0, 0, 0, 0,    0, 0, 0, 0);
        vecs[25] = mk(A, 'h1, 0,    0,    0, 0, 0, 'h1,  1, 0, 0, 'h1);
        vecs[26] = mk(A, 'h1, 0,    0,    0, 1, 0, 0,    0, 0, 0, 0);

        for (int k = 0; k < 27; k++) begin
            applyStimulus(vecs[k].mode, vecs[k].lmask, vecs[k].strb, vecs[k].base,
                          vecs[k].flush, vecs[k].cmpl, vecs[k].clr);
            checkOutput($sformatf("v%0d_valid", k), regs_valid, vecs[k].exp_valid);
            checkOutput($sformatf("v%0d_occ", k), 32'(occupancy), 32'(vecs[k].exp_occ));
            checkOutput($sformatf("v%0d_err", k), 32'(overflow_err), 32'(vecs[k].exp_err));
            checkOutput($sformatf("v%0d_lane%0d", k, vecs[k].chk_lane),
                        lane_of(vecs[k].chk_lane), vecs[k].exp_data);
        end

        // Five vectors into a four-deep queue: the fifth waits in the slot.
        for (int v = 0; v < 5; v++) begin
            applyStimulus(F, 0, 'h1, 32'h100 + v, 0, 0, 0);
            applyStimulus(F, 0, 0, 0, 1, 0, 0);
        end
        checkOutput("full_occ", 32'(occupancy), 4);
        checkOutput("full_head", lane_of(0), 'h100);
        applyStimulus(F, 0, 0, 0, 0, 0, 0);
        checkOutput("stall_occ", 32'(occupancy), 4);
        applyStimulus(F, 0, 0, 0, 1, 1, 0);
        checkOutput("stall_pop_occ", 32'(occupancy), 4);
        checkOutput("stall_pop_head", lane_of(0), 'h101);

        // Full queue with simultaneous commit and pop keeps order.
        applyStimulus(F, 0, 'h1, 'h105, 0, 0, 0);
        checkOutput("slot_wait_occ", 32'(occupancy), 4);
        applyStimulus(F, 0, 0, 0, 1, 1, 0);
        checkOutput("pushpop_occ", 32'(occupancy), 4);
        checkOutput("pushpop_head", lane_of(0), 'h102);
        for (int p = 0; p < 3; p++) begin
            applyStimulus(F, 0, 0, 0, 0, 1, 0);
            checkOutput($sformatf("drain%0d_occ", p), 32'(occupancy), 32'(3 - p));
            checkOutput($sformatf("drain%0d_head", p), lane_of(0), 32'h103 + p);
            checkOutput($sformatf("drain%0d_valid", p), regs_valid, 'h1);
        end
        applyStimulus(F, 0, 0, 0, 0, 1, 0);
        checkOutput("drained_occ", 32'(occupancy), 0);
        checkOutput("drained_valid", regs_valid, 0);
        checkOutput("drained_data", lane_of(0), 0);
        applyStimulus(F, 0, 0, 0, 0, 1, 0);
        checkOutput("empty_pop_occ", 32'(occupancy), 0);

        // Reset with three entries queued, a partial vector and a raised error.
        for (int v = 0; v < 3; v++) begin
            applyStimulus(F, 0, 'h1, 32'h200 + v, 0, 0, 0);
            applyStimulus(F, 0, 0, 0, 1, 0, 0);
        end
        applyStimulus(F, 0, 'h8, 'h1, 0, 0, 0);
        applyStimulus(F, 0, 'h8, 'h2, 0, 0, 0);
        checkOutput("pre_reset_occ", 32'(occupancy), 3);
        checkOutput("pre_reset_err", 32'(overflow_err), 1);
        reset_poweron = 1'b1;
        applyStimulus(F, 0, 'h1, 'h300, 0, 0, 0);
        reset_poweron = 1'b0;
        checkOutput("post_reset_occ", 32'(occupancy), 0);
        checkOutput("post_reset_valid", regs_valid, 0);
        checkOutput("post_reset_err", 32'(overflow_err), 0);
        checkOutput("post_reset_data", lane_of(0), 0);
        applyStimulus(F, 0, 0, 0, 1, 0, 0);
        checkOutput("post_reset_flush_occ", 32'(occupancy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
